muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit owning the HI/LO special registers.
- Replaces the combinational 64-bit ALU product and the separate HI/LO register.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles under a start/busy/done handshake, plus MTHI/MTLO writes.
- Sits beside the ALU in the datapath; the control unit stalls the PC while busy is high and an MFHI/MFLO or a new muldiv op is pending.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q, sign_a_q, sign_b_q, zdiv_q;
  logic                 busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
  assign a_ext     = {{WIDTH{signed_op & a[WIDTH-1]}}, a};
  assign b_ext     = {{WIDTH{signed_op & b[WIDTH-1]}}, b};
  assign fast_prod = a_ext * b_ext;
`endif

  always_comb begin
    fix_hi   = '0;
    fix_lo   = '0;
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    if (is_div_q) begin
      fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      {fix_hi, fix_lo} = prod_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zdiv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                dbz_q    <= 1'b0;
                busy_q   <= 1'b1;
                is_div_q <= op[1];
                sign_a_q <= signed_op & a[WIDTH-1];
                sign_b_q <= signed_op & b[WIDTH-1];
                opnd_q   <= op[1] ? b_mag : a_mag;
                acc_q    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                cnt_q    <= CNT_W'(WIDTH);
                zdiv_q   <= 1'b0;
                state_q  <= S_RUN;
                // Zero divisor: preload the raw result and let FIX pass it through
                if (op[1] && (b == '0)) begin
                  zdiv_q   <= 1'b1;
                  sign_a_q <= 1'b0;
                  sign_b_q <= 1'b0;
                  acc_q    <= {a, {WIDTH{1'b1}}};
                  state_q  <= S_FIX;
                end
`ifdef MULDIV_FAST_MUL_EN
                if (!op[1]) begin
                  sign_a_q <= 1'b0;
                  sign_b_q <= 1'b0;
                  acc_q    <= fast_prod;
                  state_q  <= S_FIX;
                end
`endif
              end
              OP_MTHI: begin
                hi_q   <= a;
                dbz_q  <= 1'b0;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= a;
                dbz_q  <= 1'b0;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          dbz_q   <= zdiv_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] bb);
    if (o[1] && bb == '0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return W + 1;
  endfunction

  // Issue one op; lat = edges after the start edge until done is seen
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic busy_seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int   lat, ndone;
  logic bsy;
  logic [W-1:0] old_hi, old_lo;

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{3'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0};
    vecs[5]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0};
    vecs[11] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bsy);
      check($sformatf("v%0d busy", i), bsy, 1);
      check($sformatf("v%0d latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
      check($sformatf("v%0d hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d dbz", i), div_by_zero, vecs[i].dbz);
      @(posedge clk); #1;
      check($sformatf("v%0d done width", i), done, 0);
    end

    // MULTU 5x5 with a DIVU start pulsed while busy; old HI/LO held meanwhile
    old_hi = vecs[11].hi;
    old_lo = vecs[11].lo;
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold hi", hi, old_hi);
    check("hold lo", lo, old_lo);
    check("dbz cleared", div_by_zero, 0);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (lat == 0) begin
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("busy-start latency", lat, exp_lat(3'd1, 32'd5));
    check("busy-start hi", hi, 0);
    check("busy-start lo", lo, 25);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("no queued op", ndone, 0);

    do_op(3'd4, 32'h0000ABCD, 32'd0, lat, bsy);
    check("mthi latency", lat, 0);
    check("mthi busy", bsy, 0);
    check("mthi hi", hi, 32'h0000ABCD);
    check("mthi lo", lo, 25);
    do_op(3'd5, 32'h00000055, 32'd0, lat, bsy);
    check("mtlo lo", lo, 32'h55);
    check("mtlo hi", hi, 32'h0000ABCD);

    // Reserved op: ignored entirely
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (3) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    check("reserved activity", ndone, 0);
    check("reserved hi", hi, 32'h0000ABCD);
    check("reserved lo", lo, 32'h55);

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midreset no done", ndone, 0);
    do_op(3'd1, 32'd3, 32'd4, lat, bsy);
    check("post-reset lo", lo, 12);
    check("post-reset hi", hi, 0);
    check("post-reset latency", lat, exp_lat(3'd1, 32'd4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
